// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 line buffer feeding the convolution datapath.
// Contents:
//   DEF_PIXEL_W  default pixel width in bits
//   WIN_DIM      window edge length (3)
//   state_e      line buffer sequencing states {IDLE, FILL, RUN}
//   win_off()    bit offset of window element (r,c) inside the packed window
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int DEF_PIXEL_W = 8;
  localparam int WIN_DIM     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Row 0 is the oldest row and column 0 the oldest column, so element (0,0)
  // sits in the least significant slot of the packed window.
  function automatic int win_off(input int r, input int c, input int pix_w);
    return pix_w * (WIN_DIM * r + c);
  endfunction

endpackage : conv_pkg

// File: rtl/line_mem.sv
// -----------------------------------------------------------------------------
// line_mem
// Single-port DEPTH x WIDTH line memory with read-before-write behaviour:
// the read port is combinational, so in a cycle that writes an address the
// read data is still the old contents. Contents are never cleared.
// Ports:
//   clk      system clock, write on rising edge
//   we_i     write enable
//   addr_i   read/write address (0..DEPTH-1)
//   wdata_i  write data
//   rdata_o  current contents of addr_i (value before any write this cycle)
// -----------------------------------------------------------------------------
module line_mem #(
  parameter int DEPTH = 220,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule : line_mem

// File: rtl/line_buffer_3x3.sv
// -----------------------------------------------------------------------------
// line_buffer_3x3
// Accepts a raster-order pixel stream, keeps the two previous image rows in
// line memories and forms a 3x3 sliding window. A window is flagged valid one
// clock after the pixel that completes it, only when that pixel has row>=2 and
// col>=2, so windows straddling a row wrap or using stale rows are never
// flagged.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   pix_valid   pix_in is valid and accepted this cycle
//   pix_in      pixel data, raster order
//   win_valid   win_out holds a complete window
//   win_out     packed 3x3 window, element (r,c) at PIXEL_W*(3r+c)
//   frame_done  pulse with the window of the frame's last pixel
//   frame_cnt   (only with LINE_BUF_FRAME_CNT_EN) 16-bit completed-frame count
// Optional build macro: LINE_BUF_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module line_buffer_3x3
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int PIXEL_W    = DEF_PIXEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic [PIXEL_W-1:0]     pix_in,
  output logic                   win_valid,
  output logic [9*PIXEL_W-1:0]   win_out,
  output logic                   frame_done
`ifdef LINE_BUF_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  state_e             state_q, state_d;
  logic               winValid_q, winValid_d;
  logic               frameDone_q, frameDone_d;
  logic [PIXEL_W-1:0] win_q [WIN_DIM][WIN_DIM];
  logic [PIXEL_W-1:0] win_d [WIN_DIM][WIN_DIM];
  logic [PIXEL_W-1:0] line0Rd, line1Rd;
  logic               colLast, rowLast, lastPix, colWinOk;

  // Position decodes compare at full integer width against the parameters.
  assign colLast  = (32'(col_q) == 32'(IMG_WIDTH - 1));
  assign rowLast  = (32'(row_q) == 32'(IMG_HEIGHT - 1));
  assign lastPix  = colLast && rowLast;
  assign colWinOk = (32'(col_q) >= 32'd2);

  // line0 holds the previous row, line1 the row before it. Because the reads
  // are taken before the write lands, line0's old contents cascade into line1
  // in the same cycle the new pixel overwrites line0.
  line_mem #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W),
    .AW    (CW)
  ) u_line0 (
    .clk     (clk),
    .we_i    (pix_valid),
    .addr_i  (col_q),
    .wdata_i (pix_in),
    .rdata_o (line0Rd)
  );

  line_mem #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W),
    .AW    (CW)
  ) u_line1 (
    .clk     (clk),
    .we_i    (pix_valid),
    .addr_i  (col_q),
    .wdata_i (line0Rd),
    .rdata_o (line1Rd)
  );

  // Raster position: col wraps into row, row wraps back to the frame start.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (colLast) begin
        col_d = '0;
        row_d = rowLast ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // FILL covers the first two rows, which only prime the line memories; RUN
  // covers the rows whose windows can be complete.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pix_valid) state_d = FILL;
      FILL: if (pix_valid && colLast && (32'(row_q) == 32'd1)) state_d = RUN;
      RUN:  if (pix_valid && lastPix) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window shifts left on each accepted pixel; the new right-hand column is
  // the current column from the two stored rows plus the incoming pixel.
  always_comb begin
    win_d = win_q;
    if (pix_valid) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = line1Rd;
      win_d[1][2] = line0Rd;
      win_d[2][2] = pix_in;
    end
  end

  assign winValid_d  = pix_valid && (state_q == RUN) && colWinOk;
  assign frameDone_d = pix_valid && (state_q == RUN) && lastPix;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      state_q     <= IDLE;
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
      win_q       <= '{default: '0};
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      state_q     <= state_d;
      winValid_q  <= winValid_d;
      frameDone_q <= frameDone_d;
      win_q       <= win_d;
    end
  end

  // Pack the register window into the flat output bus.
  always_comb begin
    win_out = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        win_out[win_off(r, c, PIXEL_W) +: PIXEL_W] = win_q[r][c];
      end
    end
  end

  assign win_valid  = winValid_q;
  assign frame_done = frameDone_q;

`ifdef LINE_BUF_FRAME_CNT_EN
  logic [15:0] frameCnt_q, frameCnt_d;

  // Counts on the same edge that raises frame_done; wraps naturally at 16 bits.
  assign frameCnt_d = frameDone_d ? frameCnt_q + 16'd1 : frameCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frameCnt_q <= '0;
    end else begin
      frameCnt_q <= frameCnt_d;
    end
  end

  assign frame_cnt = frameCnt_q;
`endif

endmodule : line_buffer_3x3
